// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_pkg
//  Description : Shared types and constants for the MAC lookup front end
//                (header capture, arbiter and mac_learning interface).
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int MAC_W  = 48;
    localparam int PORT_W = 3;

    // Flood code returned when mac_learning never answers
    localparam logic [PORT_W-1:0] FLOOD_PORT = 3'd7;

    // Header is 6 bytes destination MAC followed by 6 bytes source MAC
    localparam logic [3:0] HDR_BYTES = 4'd12;
    localparam logic [3:0] HDR_LAST  = 4'd11;

    typedef logic [MAC_W-1:0]  mac_t;
    typedef logic [PORT_W-1:0] port_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_hdr_capture.sv
`default_nettype none
// ============================================================================
//  Module      : mac_hdr_capture
//  Description : Per-port capture of the 12-byte Ethernet MAC header. Holds a
//                completed header (pending) until the arbiter releases it.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_hdr_capture
    import mac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             sof,
    input  logic [7:0]       data,
    input  logic             clr_pending,
    output logic             pending,
    output logic [MAC_W-1:0] dst_mac,
    output logic [MAC_W-1:0] src_mac,
    output logic             drop
);

    // cnt = number of header bytes taken so far; 0 = no frame, 12 = payload
    logic [3:0]         cnt;
    logic [2*MAC_W-1:0] hdr;
    logic               take_sof;
    logic               take_byte;
    logic               last_byte;

    // A sof is refused only while an older header is still waiting, unless
    // that header is being released in this very cycle.
    assign take_sof  = valid & sof & (~pending | clr_pending);
    assign drop      = valid & sof & pending & ~clr_pending;
    assign take_byte = valid & ~sof & (cnt != 4'd0) & (cnt < HDR_BYTES);
    assign last_byte = take_byte & (cnt == HDR_LAST);

    // Bytes shift in MSB first, so after 12 shifts the upper half is the
    // destination MAC and the lower half the source MAC.
    assign dst_mac = hdr[2*MAC_W-1:MAC_W];
    assign src_mac = hdr[MAC_W-1:0];

    // Byte counter, header shift register and pending flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            hdr     <= '0;
            pending <= 1'b0;
        end else begin
            if (take_sof) begin
                hdr <= {hdr[2*MAC_W-9:0], data};
                cnt <= 4'd1;
            end else if (take_byte) begin
                hdr <= {hdr[2*MAC_W-9:0], data};
                cnt <= cnt + 4'd1;
            end

            if (last_byte) begin
                pending <= 1'b1;
            end else if (clr_pending) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lookup_arbiter
//  Description : Captures MAC headers on each ingress port, arbitrates
//                round-robin among completed headers, issues one lookup at a
//                time to mac_learning and returns the forwarding decision.
//                A watchdog floods if mac_learning never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lookup_arbiter #(
    parameter int                NUM_PORTS    = 5,
    parameter int                PORT_W       = 3,
    parameter int                DONE_TIMEOUT = 64,
    parameter logic [PORT_W-1:0] FLOOD_PORT   = PORT_W'(7)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   rx_valid,
    input  logic [NUM_PORTS-1:0]   rx_sof,
    input  logic [8*NUM_PORTS-1:0] rx_data,
    output logic [NUM_PORTS-1:0]   hdr_drop,
    output logic                   lu_en,
    output logic [47:0]            lu_dst_mac,
    output logic [47:0]            lu_src_mac,
    output logic [PORT_W-1:0]      lu_src_port,
    input  logic                   lu_done,
    input  logic [PORT_W-1:0]      lu_dst_port,
    output logic                   resp_valid,
    output logic [PORT_W-1:0]      resp_port,
    output logic [PORT_W-1:0]      resp_dst_port,
    output logic                   resp_timeout
);
    import mac_pkg::*;

    localparam int WD_W = $clog2(DONE_TIMEOUT);

    arb_state_t          state_q;
    arb_state_t          state_d;
    logic [NUM_PORTS-1:0] pending;
    logic [NUM_PORTS-1:0] clr_pending;
    mac_t                cap_dst [NUM_PORTS];
    mac_t                cap_src [NUM_PORTS];
    logic [PORT_W-1:0]   grant_q;
    logic [PORT_W-1:0]   last_grant_q;
    logic [PORT_W-1:0]   next_grant;
    logic [PORT_W-1:0]   cand;
    logic                found;
    logic [WD_W-1:0]     wd_q;
    logic                wd_expired;
    logic [PORT_W-1:0]   res_dst_q;
    logic                res_to_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mac_hdr_capture u_cap (
            .clk         (clk),
            .rst         (rst),
            .valid       (rx_valid[p]),
            .sof         (rx_sof[p]),
            .data        (rx_data[8*p +: 8]),
            .clr_pending (clr_pending[p]),
            .pending     (pending[p]),
            .dst_mac     (cap_dst[p]),
            .src_mac     (cap_src[p]),
            .drop        (hdr_drop[p])
        );
    end

    // Round-robin pick: first pending port after the last one served
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant_q;
        cand       = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = PORT_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!found && pending[cand]) begin
                found      = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Release the served header while its result is being returned
    always_comb begin
        clr_pending = '0;
        if (state_q == RESP) begin
            clr_pending[grant_q] = 1'b1;
        end
    end

    assign wd_expired = (wd_q == WD_W'(DONE_TIMEOUT - 1));

    // Arbiter next-state decode; lu_done only matters while waiting
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (lu_done || wd_expired) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, lookup request fields, watchdog and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q      <= '0;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            lu_dst_mac   <= '0;
            lu_src_mac   <= '0;
            wd_q         <= '0;
            res_dst_q    <= '0;
            res_to_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q    <= next_grant;
                        lu_dst_mac <= cap_dst[next_grant];
                        lu_src_mac <= cap_src[next_grant];
                    end
                end
                ISSUE: begin
                    wd_q <= '0;
                end
                WAIT: begin
                    wd_q <= wd_q + WD_W'(1);
                    // A real answer beats the watchdog in the same cycle
                    if (lu_done) begin
                        res_dst_q <= lu_dst_port;
                        res_to_q  <= 1'b0;
                    end else if (wd_expired) begin
                        res_dst_q <= FLOOD_PORT;
                        res_to_q  <= 1'b1;
                    end
                end
                RESP: begin
                    last_grant_q <= grant_q;
                end
                default: begin
                end
            endcase
        end
    end

    assign lu_en         = (state_q == ISSUE);
    assign lu_src_port   = grant_q;
    assign resp_valid    = (state_q == RESP);
    assign resp_port     = resp_valid ? grant_q   : '0;
    assign resp_dst_port = resp_valid ? res_dst_q : '0;
    assign resp_timeout  = resp_valid & res_to_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mac_lookup_arbiter
//  Description : Self-checking bench for mac_lookup_arbiter. Expected lookup
//                requests and responses are queued as stimulus is driven and
//                checked when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_lookup_arbiter;

    localparam int NP  = 5;
    localparam int DTO = 64;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   rx_valid;
    logic [NP-1:0]   rx_sof;
    logic [8*NP-1:0] rx_data;
    logic [NP-1:0]   hdr_drop;
    logic            lu_en;
    logic [47:0]     lu_dst_mac;
    logic [47:0]     lu_src_mac;
    logic [2:0]      lu_src_port;
    logic            lu_done;
    logic [2:0]      lu_dst_port;
    logic            resp_valid;
    logic [2:0]      resp_port;
    logic [2:0]      resp_dst_port;
    logic            resp_timeout;

    mac_lookup_arbiter #(
        .NUM_PORTS    (NP),
        .PORT_W       (3),
        .DONE_TIMEOUT (DTO),
        .FLOOD_PORT   (3'd7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_sof        (rx_sof),
        .rx_data       (rx_data),
        .hdr_drop      (hdr_drop),
        .lu_en         (lu_en),
        .lu_dst_mac    (lu_dst_mac),
        .lu_src_mac    (lu_src_mac),
        .lu_src_port   (lu_src_port),
        .lu_done       (lu_done),
        .lu_dst_port   (lu_dst_port),
        .resp_valid    (resp_valid),
        .resp_port     (resp_port),
        .resp_dst_port (resp_dst_port),
        .resp_timeout  (resp_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [47:0] dst;
        logic [47:0] src;
        logic [2:0]  port;
    } lu_t;

    typedef struct packed {
        logic [2:0] port;
        logic [2:0] dp;
        logic       to;
    } resp_t;

    typedef struct {
        logic [2:0]  port;
        logic [47:0] dst;
        logic [47:0] src;
        int          delay;
        logic [2:0]  dp;
    } vec_t;

    lu_t         exp_lu[$];
    resp_t       exp_resp[$];
    lu_t         mon_lu;
    resp_t       mon_resp;
    logic [47:0] hdr_dst [NP];
    logic [47:0] hdr_src [NP];
    vec_t        vt [4];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hb(input int p, input int k);
        logic [95:0] h;
        h = {hdr_dst[p], hdr_src[p]};
        return h[95-8*k -: 8];
    endfunction

    // Drive header bytes first..last on every port in mask (byte 0 carries sof)
    task automatic drive_bytes(input logic [NP-1:0] mask, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            @(posedge clk); #1;
            rx_valid = mask;
            rx_sof   = (k == 0) ? mask : '0;
            for (int p = 0; p < NP; p++) rx_data[8*p +: 8] = hb(p, k);
        end
        @(posedge clk); #1;
        rx_valid = '0;
        rx_sof   = '0;
    endtask

    task automatic push_lu(input int p);
        exp_lu.push_back(lu_t'{dst: hdr_dst[p], src: hdr_src[p], port: 3'(p)});
    endtask

    task automatic wait_lu_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lu_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("lu_en_wait", lu_en, 1'b1);
    endtask

    // Act as mac_learning for one request; flood=1 means never answer
    task automatic serve(input int delay, input logic [2:0] dp, input logic [2:0] port, input bit flood);
        bit ok;
        exp_resp.push_back(resp_t'{port: port, dp: flood ? 3'd7 : dp, to: flood});
        wait_lu_en(ok);
        if (!flood) begin
            repeat (delay) @(posedge clk);
            #1 lu_done = 1'b1; lu_dst_port = dp;
            @(posedge clk);
            #1 lu_done = 1'b0; lu_dst_port = '0;
        end
    endtask

    // Scoreboard: every lookup request and every response is popped and compared
    always @(negedge clk) begin
        if (lu_en) begin
            if (exp_lu.size() == 0) chk("lu_unexpected", lu_en, 1'b0);
            else begin
                mon_lu = exp_lu.pop_front();
                chk("lu_req", {lu_dst_mac, lu_src_mac, lu_src_port}, mon_lu);
            end
        end
        if (resp_valid) begin
            if (exp_resp.size() == 0) chk("resp_unexpected", resp_valid, 1'b0);
            else begin
                mon_resp = exp_resp.pop_front();
                chk("resp", {resp_port, resp_dst_port, resp_timeout}, mon_resp);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cnt;

        vt[0] = '{port: 3'd2, dst: 48'h0123456789AB, src: 48'h001122334455, delay: 3,  dp: 3'd4};
        vt[1] = '{port: 3'd0, dst: 48'hFFFFFFFFFFFF, src: 48'h0A0B0C0D0E0F, delay: 1,  dp: 3'd1};
        vt[2] = '{port: 3'd3, dst: 48'h800000000001, src: 48'h7FFFFFFFFFFE, delay: 10, dp: 3'd0};
        vt[3] = '{port: 3'd4, dst: 48'h5A5AA5A55A5A, src: 48'hC3C3C3C3C3C3, delay: 2,  dp: 3'd6};

        rst = 1'b0; rx_valid = '0; rx_sof = '0; rx_data = '0;
        lu_done = 1'b0; lu_dst_port = '0;
        for (int p = 0; p < NP; p++) begin hdr_dst[p] = '0; hdr_src[p] = '0; end

        repeat (2) @(negedge clk);
        chk("reset_outputs", {hdr_drop, lu_en, lu_dst_mac, lu_src_mac, lu_src_port,
                              resp_valid, resp_port, resp_dst_port, resp_timeout}, '0);
        @(posedge clk); #1 rst = 1'b1;

        // lu_done while idle must be ignored
        @(posedge clk); #1 lu_done = 1'b1; lu_dst_port = 3'd5;
        @(posedge clk); #1 lu_done = 1'b0; lu_dst_port = '0;
        @(negedge clk); chk("idle_done_ignored", resp_valid, 1'b0);

        // Table: one port at a time, check request latency and response latency
        for (int v = 0; v < 4; v++) begin
            hdr_dst[vt[v].port] = vt[v].dst;
            hdr_src[vt[v].port] = vt[v].src;
            push_lu(int'(vt[v].port));
            exp_resp.push_back(resp_t'{port: vt[v].port, dp: vt[v].dp, to: 1'b0});
            drive_bytes(NP'(1) << vt[v].port, 0, 11);
            @(negedge clk); chk("lu_en_t1", lu_en, 1'b0);
            @(negedge clk); chk("lu_en_t2", lu_en, 1'b1);
            repeat (vt[v].delay) @(posedge clk);
            #1 lu_done = 1'b1; lu_dst_port = vt[v].dp;
            @(posedge clk); #1 lu_done = 1'b0; lu_dst_port = '0;
            @(negedge clk); chk("resp_d1", resp_valid, 1'b1);
            @(negedge clk); chk("resp_one_cycle", resp_valid, 1'b0);
        end

        // Three simultaneous headers after port 4 was served: order 0, 1, 3
        hdr_dst[0] = 48'h000000000100; hdr_src[0] = 48'h111111111111;
        hdr_dst[1] = 48'h000000000101; hdr_src[1] = 48'h222222222222;
        hdr_dst[3] = 48'h000000000103; hdr_src[3] = 48'h333333333333;
        push_lu(0); push_lu(1); push_lu(3);
        drive_bytes(5'b01011, 0, 11);
        serve(5, 3'd1, 3'd0, 1'b0);
        serve(5, 3'd2, 3'd1, 1'b0);
        serve(5, 3'd3, 3'd3, 1'b0);
        // Last grant is 3: port 4 goes ahead of port 0
        hdr_dst[0] = 48'hAAAAAAAAAA00; hdr_src[0] = 48'hBBBBBBBBBB00;
        hdr_dst[4] = 48'hAAAAAAAAAA04; hdr_src[4] = 48'hBBBBBBBBBB04;
        push_lu(4); push_lu(0);
        drive_bytes(5'b10001, 0, 11);
        serve(5, 3'd0, 3'd4, 1'b0);
        serve(5, 3'd2, 3'd0, 1'b0);

        // Watchdog: port 2 never answered, port 3 then served normally
        hdr_dst[2] = 48'hDEADBEEF0002; hdr_src[2] = 48'h020202020202;
        hdr_dst[3] = 48'hDEADBEEF0003; hdr_src[3] = 48'h030303030303;
        push_lu(2); push_lu(3);
        drive_bytes(5'b01100, 0, 11);
        serve(0, 3'd0, 3'd2, 1'b1);
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk); cnt++;
            if (resp_valid) break;
        end
        chk("wd_latency", cnt, DTO + 1);
        serve(2, 3'd6, 3'd3, 1'b0);

        // Drop: port 1 pending while port 0 is stuck in WAIT, then a new sof on 1
        hdr_dst[0] = 48'h0000000000A0; hdr_src[0] = 48'h0000000000B0;
        push_lu(0);
        exp_resp.push_back(resp_t'{port: 3'd0, dp: 3'd5, to: 1'b0});
        drive_bytes(5'b00001, 0, 11);
        hdr_dst[1] = 48'h1234567890AB; hdr_src[1] = 48'hCAFEF00D1234;
        push_lu(1);
        fork
            begin
                wait_lu_en(ok);
                repeat (40) @(posedge clk);
                #1 lu_done = 1'b1; lu_dst_port = 3'd5;
                @(posedge clk); #1 lu_done = 1'b0; lu_dst_port = '0;
            end
            begin
                drive_bytes(5'b00010, 0, 11);
                repeat (2) @(posedge clk);
                hdr_dst[1] = 48'hEEEEEEEEEEEE; hdr_src[1] = 48'hDDDDDDDDDDDD;
                @(posedge clk); #1;
                rx_valid = 5'b00010; rx_sof = 5'b00010; rx_data[15:8] = hb(1, 0);
                @(negedge clk); chk("hdr_drop_pulse", hdr_drop, 5'b00010);
                @(posedge clk); #1 rx_valid = '0; rx_sof = '0;
                @(negedge clk); chk("hdr_drop_clear", hdr_drop, 5'b00000);
                drive_bytes(5'b00010, 1, 11);
            end
        join
        // Port 1 granted with original MACs; sof in its RESP cycle is accepted
        hdr_dst[1] = 48'h0F0F0F0F0F0F; hdr_src[1] = 48'hF0F0F0F0F0F0;
        exp_resp.push_back(resp_t'{port: 3'd1, dp: 3'd2, to: 1'b0});
        push_lu(1);
        wait_lu_en(ok);
        repeat (3) @(posedge clk);
        #1 lu_done = 1'b1; lu_dst_port = 3'd2;
        fork
            drive_bytes(5'b00010, 0, 11);
            begin
                @(posedge clk); #1 lu_done = 1'b0; lu_dst_port = '0;
                @(negedge clk);
                chk("resp_cycle_valid", resp_valid, 1'b1);
                chk("resp_cycle_no_drop", hdr_drop, 5'b00000);
            end
        join
        serve(2, 3'd3, 3'd1, 1'b0);

        // Runt on port 0 followed by a full header: only the second is looked up
        hdr_dst[0] = 48'h999999999999; hdr_src[0] = 48'h888888888888;
        drive_bytes(5'b00001, 0, 4);
        hdr_dst[0] = 48'h0102030405FF; hdr_src[0] = 48'h060708090AFE;
        push_lu(0);
        drive_bytes(5'b00001, 0, 11);
        serve(1, 3'd4, 3'd0, 1'b0);

        // Reset during WAIT abandons the lookup
        hdr_dst[2] = 48'h222222220002; hdr_src[2] = 48'h333333330002;
        push_lu(2);
        drive_bytes(5'b00100, 0, 11);
        wait_lu_en(ok);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun_reset_outputs", {hdr_drop, lu_en, lu_dst_mac, lu_src_mac, lu_src_port,
                                     resp_valid, resp_port, resp_dst_port, resp_timeout}, '0);
        @(posedge clk); #1 rst = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) cnt++;
        end
        chk("no_resp_after_reset", cnt, 0);
        // After reset port 0 wins over port 3
        hdr_dst[0] = 48'h00000000F000; hdr_src[0] = 48'h00000000E000;
        hdr_dst[3] = 48'h00000000F003; hdr_src[3] = 48'h00000000E003;
        push_lu(0); push_lu(3);
        drive_bytes(5'b01001, 0, 11);
        serve(2, 3'd1, 3'd0, 1'b0);
        serve(2, 3'd2, 3'd3, 1'b0);

        repeat (10) @(negedge clk);
        chk("lu_queue_empty", exp_lu.size(), 0);
        chk("resp_queue_empty", exp_resp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
